booth_mul_arbiter: RTL

- Shares one 8x8 signed BoothMultiplier between two requesters (ALU port 0, ALU port 1).
- Arbitrates round-robin, captures the winner's operands and pulses the multiplier's start.
- Waits for done, then returns the 16-bit product to the granted requester with a one-cycle valid.
- Sits between the ALU issue logic and a single multiplier instance; the multiplier is instantiated outside this block.

---
 rtl/alu_pkg.sv | 17 +
 rtl/booth_mul_arbiter_if.sv | 20 ++
 rtl/booth_mul_arbiter_rr_arb2.sv | 23 ++
 rtl/booth_mul_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and defaults for the multiplier arbiter
package alu_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        SETTLE = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } state_t;

    // Index of a requester: 0 = ALU port 0, 1 = ALU port 1
    typedef logic grant_t;

endpackage

// File: rtl/booth_mul_arbiter_if.sv
// rtl/booth_mul_arbiter_if.sv - bus between the arbiter and the shared multiplier
interface booth_mul_arbiter_if #(
    parameter int WIDTH = 8
);
    logic                 mul_start;
    logic [WIDTH-1:0]     mul_multiplicand;
    logic [WIDTH-1:0]     mul_multiplier;
    logic [2*WIDTH-1:0]   mul_outbus;
    logic                 mul_done;

    modport master (
        output mul_start, mul_multiplicand, mul_multiplier,
        input  mul_outbus, mul_done
    );

    modport slave (
        input  mul_start, mul_multiplicand, mul_multiplier,
        output mul_outbus, mul_done
    );
endinterface

// File: rtl/booth_mul_arbiter_rr_arb2.sv
// rtl/booth_mul_arbiter_rr_arb2.sv - two-way round-robin picker
module rr_arb2
    import alu_pkg::*;
(
    input  logic [1:0] req,
    input  grant_t     last_grant,
    input  logic       enable,
    output logic [1:0] gnt
);

    // A lone request wins outright; on a tie the port not served last wins
    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                gnt = (last_grant == 1'b1) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/booth_mul_arbiter.sv
// rtl/booth_mul_arbiter.sv - shares one signed multiplier between two ALU ports
module booth_mul_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEFAULT,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    output logic                 ack0,
    output logic                 rsp_valid0,
    output logic [2*WIDTH-1:0]   result0,
    output logic                 rsp_err0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 ack1,
    output logic                 rsp_valid1,
    output logic [2*WIDTH-1:0]   result1,
    output logic                 rsp_err1,
    booth_mul_arbiter_if.master  mul,
    output logic                 busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t               state_q, state_d;
    grant_t               owner_q, owner_d;
    grant_t               last_grant_q, last_grant_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     mul_a_q, mul_a_d;
    logic [WIDTH-1:0]     mul_b_q, mul_b_d;
    logic [2*WIDTH-1:0]   result0_q, result0_d;
    logic [2*WIDTH-1:0]   result1_q, result1_d;
    logic                 err0_q, err0_d;
    logic                 err1_q, err1_d;
    logic                 mul_start_c;
    logic [1:0]           gnt;

    rr_arb2 u_arb (
        .req        ({req1, req0}),
        .last_grant (last_grant_q),
        .enable     ((state_q == IDLE) && !rst),
        .gnt        (gnt)
    );

    // Next-state and handshake outputs; SETTLE masks a done left over from the previous product
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        result0_d    = result0_q;
        result1_d    = result1_q;
        err0_d       = err0_q;
        err1_d       = err1_q;
        ack0         = 1'b0;
        ack1         = 1'b0;
        mul_start_c  = 1'b0;
        rsp_valid0   = 1'b0;
        rsp_valid1   = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt[0]) begin
                    ack0         = 1'b1;
                    mul_a_d      = a0;
                    mul_b_d      = b0;
                    owner_d      = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = START;
                end else if (gnt[1]) begin
                    ack1         = 1'b1;
                    mul_a_d      = a1;
                    mul_b_d      = b1;
                    owner_d      = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = START;
                end
            end
            START: begin
                mul_start_c = 1'b1;
                state_d     = SETTLE;
            end
            SETTLE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (mul.mul_done) begin
                    if (owner_q == 1'b0) begin
                        result0_d = mul.mul_outbus;
                        err0_d    = 1'b0;
                    end else begin
                        result1_d = mul.mul_outbus;
                        err1_d    = 1'b0;
                    end
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    if (owner_q == 1'b0) begin
                        result0_d = '0;
                        err0_d    = 1'b1;
                    end else begin
                        result1_d = '0;
                        err1_d    = 1'b1;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                rsp_valid0 = (owner_q == 1'b0);
                rsp_valid1 = (owner_q == 1'b1);
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            ack0        = 1'b0;
            ack1        = 1'b0;
            mul_start_c = 1'b0;
            rsp_valid0  = 1'b0;
            rsp_valid1  = 1'b0;
        end
    end

    // State and datapath registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            result0_q    <= '0;
            result1_q    <= '0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            result0_q    <= result0_d;
            result1_q    <= result1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
        end
    end

    assign mul.mul_start        = mul_start_c;
    assign mul.mul_multiplicand = mul_a_q;
    assign mul.mul_multiplier   = mul_b_q;
    assign result0              = result0_q;
    assign result1              = result1_q;
    assign rsp_err0             = err0_q;
    assign rsp_err1             = err1_q;
    assign busy                 = (state_q != IDLE) && !rst;

endmodule
